// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and widths for the FIFO write-port arbiter.
package fifo_arb_pkg;

   localparam int BYTE_W = 8;
   localparam int CNT_W  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TAG  = 2'd1,
      XFER = 2'd2
   } arb_state_t;

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Source byte streams plus the FIFO write port, bundled for the arbiter.
interface fifo_write_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int NUM_SRC = 4
);
   // Handshake: a source byte moves when src_valid[i] && src_ready[i] are both
   // high in the same cycle; src_last is only meaningful while src_valid is high.
   // The FIFO takes a byte on every cycle fifo_wr_en is high.
   logic [NUM_SRC-1:0]        src_valid;
   logic [NUM_SRC*BYTE_W-1:0] src_data;
   logic [NUM_SRC-1:0]        src_last;
   logic [NUM_SRC-1:0]        src_ready;
   logic                      fifo_full;
   logic                      fifo_wr_en;
   logic [BYTE_W-1:0]         fifo_wr_data;

   modport master (
      output src_valid, src_data, src_last, fifo_full,
      input  src_ready, fifo_wr_en, fifo_wr_data
   );

   modport slave (
      input  src_valid, src_data, src_last, fifo_full,
      output src_ready, fifo_wr_en, fifo_wr_data
   );

endinterface

// File: rtl/fifo_write_arbiter_rr_priority_picker.sv
// Combinational round-robin search: first requester at or after ptr, wrapping.
module rr_priority_picker #(
   parameter  int NUM_SRC = 4,
   localparam int SEL_W   = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic               found,
   output logic [SEL_W-1:0]   winner
);

   always_comb begin
      logic [SEL_W-1:0] idx;
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         idx = SEL_W'((int'(ptr) + i) % NUM_SRC);
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Packet-granular round-robin arbiter for the byte FIFO write port.
// Define SRC_TAG_EN to prefix every packet with a one-byte source index header.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int NUM_SRC = 4,
   localparam int SEL_W   = $clog2(NUM_SRC)
) (
   input  logic              clk,
   input  logic              rst,
   fifo_write_arbiter_if.slave bus,
   output logic              busy,
   output logic [SEL_W-1:0]  cur_src,
   output logic [CNT_W-1:0]  pkt_count,
   output arb_state_t        dbg_state
);

   arb_state_t        state;
   logic [SEL_W-1:0]  rr_ptr;
   logic [SEL_W-1:0]  winner;
   logic [SEL_W-1:0]  next_ptr;
   logic              found;
   logic              sel_valid;
   logic              sel_last;
   logic [BYTE_W-1:0] sel_data;
   logic              pkt_done;

   rr_priority_picker #(.NUM_SRC(NUM_SRC)) picker (
      .req    (bus.src_valid),
      .ptr    (rr_ptr),
      .found  (found),
      .winner (winner)
   );

   assign sel_valid = bus.src_valid[cur_src];
   assign sel_last  = bus.src_last[cur_src];
   assign sel_data  = bus.src_data[{cur_src, 3'b000} +: BYTE_W];
   assign next_ptr  = (cur_src == SEL_W'(NUM_SRC - 1)) ? '0 : cur_src + 1'b1;
   assign pkt_done  = (state == XFER) && sel_valid && sel_last && !bus.fifo_full;

   assign busy      = (state != IDLE);
   assign dbg_state = state;

   // Bytes pass straight through in the cycle they are accepted.
   always_comb begin
      bus.src_ready    = '0;
      bus.fifo_wr_en   = 1'b0;
      bus.fifo_wr_data = '0;
      case (state)
`ifdef SRC_TAG_EN
         TAG: begin
            bus.fifo_wr_en   = !bus.fifo_full;
            bus.fifo_wr_data = bus.fifo_full ? '0 : BYTE_W'(cur_src);
         end
`endif
         XFER: begin
            bus.src_ready[cur_src] = !bus.fifo_full;
            bus.fifo_wr_en         = sel_valid && !bus.fifo_full;
            bus.fifo_wr_data       = (sel_valid && !bus.fifo_full) ? sel_data : '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cur_src   <= '0;
         rr_ptr    <= '0;
         pkt_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  cur_src <= winner;
`ifdef SRC_TAG_EN
                  state   <= TAG;
`else
                  state   <= XFER;
`endif
               end
            end
`ifdef SRC_TAG_EN
            TAG: begin
               if (!bus.fifo_full) state <= XFER;
            end
`endif
            XFER: begin
               // Grant is held through valid gaps until the last byte is taken.
               if (pkt_done) begin
                  rr_ptr    <= next_ptr;
                  pkt_count <= pkt_count + 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: per-source packet queues, expected FIFO byte queue.
module tb_fifo_write_arbiter;
   import fifo_arb_pkg::*;

   localparam int NUM_SRC = 4;
   localparam int SEL_W   = 2;
`ifdef SRC_TAG_EN
   localparam int TAGN = 1;
`else
   localparam int TAGN = 0;
`endif

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic [3:0] gap;
   } beat_t;

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic             busy;
   logic [SEL_W-1:0] cur_src;
   logic [15:0]      pkt_count;
   arb_state_t       dbg_state;

   fifo_write_arbiter_if #(.NUM_SRC(NUM_SRC)) bus ();

   fifo_write_arbiter #(.NUM_SRC(NUM_SRC)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .busy      (busy),
      .cur_src   (cur_src),
      .pkt_count (pkt_count),
      .dbg_state (dbg_state)
   );

   int         vectors     = 0;
   int         miscompares = 0;
   int         cyc         = 0;
   logic [7:0] exp_q[$];
   int         wcyc[$];
   beat_t      src_q[NUM_SRC][$];
   int         gap_left[NUM_SRC];
   bit         accepted[NUM_SRC];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string tag, logic [31:0] got, logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   // driver: present the head beat of each source queue
   task automatic drive_srcs();
      logic [NUM_SRC-1:0]   v;
      logic [NUM_SRC-1:0]   l;
      logic [NUM_SRC*8-1:0] d;
      v = '0;
      l = '0;
      d = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (src_q[i].size() == 0) begin
            gap_left[i] = 0;
         end else if (gap_left[i] > 0) begin
            gap_left[i]--;
            l[i]           = 1'b1;   // last without valid must be ignored
            d[i*8 +: 8]    = 8'hEE;
         end else begin
            v[i]           = 1'b1;
            l[i]           = src_q[i][0].last;
            d[i*8 +: 8]    = src_q[i][0].data;
         end
      end
      bus.src_valid = v;
      bus.src_last  = l;
      bus.src_data  = d;
   endtask

   task automatic send(int s, int n, logic [7:0] base, logic [7:0] step, int gap_at, int gap_len);
      beat_t b;
      if (TAGN != 0) exp_q.push_back(8'(s));
      for (int k = 0; k < n; k++) begin
         b.data = base + 8'(k) * step;
         b.last = (k == n - 1);
         b.gap  = (k == gap_at) ? 4'(gap_len) : 4'd0;
         src_q[s].push_back(b);
         exp_q.push_back(b.data);
      end
   endtask

   // monitor + scoreboard, then advance the sources after the edge
   initial begin
      for (int i = 0; i < NUM_SRC; i++) begin
         gap_left[i] = 0;
         accepted[i] = 1'b0;
      end
      drive_srcs();
      forever begin
         @(negedge clk);
         for (int i = 0; i < NUM_SRC; i++)
            accepted[i] = bus.src_valid[i] && bus.src_ready[i];
         if (bus.fifo_full) begin
            check("full_ready", 32'(bus.src_ready), 0);
            check("full_wr_en", 32'(bus.fifo_wr_en), 0);
         end
         if (bus.fifo_wr_en) begin
            wcyc.push_back(cyc);
            if (exp_q.size() == 0) check("extra_write", 32'(bus.fifo_wr_data), 32'hFFFF_FFFF);
            else check("wr_data", 32'(bus.fifo_wr_data), 32'(exp_q.pop_front()));
         end
         @(posedge clk);
         #1;
         for (int i = 0; i < NUM_SRC; i++) begin
            if (accepted[i] && src_q[i].size() > 0) begin
               void'(src_q[i].pop_front());
               if (src_q[i].size() > 0) gap_left[i] = int'(src_q[i][0].gap);
            end
         end
         drive_srcs();
      end
   end

   function automatic bit pending();
      bit p;
      p = (exp_q.size() != 0) || busy;
      for (int i = 0; i < NUM_SRC; i++)
         if (src_q[i].size() != 0) p = 1'b1;
      return p;
   endfunction

   task automatic wait_done(string tag, int max);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #3;
         n++;
      end while (pending() && n < max);
      check({tag, "_done"}, 32'(pending()), 0);
   endtask

   task automatic wait_writes(string tag, int target, int max);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #3;
         n++;
      end while (wcyc.size() < target && n < max);
      check({tag, "_writes"}, 32'(wcyc.size() >= target), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int b0;
      int p;
      int order[3];
      rst           = 1'b1;
      bus.fifo_full = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("rst_ready", 32'(bus.src_ready), 0);
      check("rst_wr_en", 32'(bus.fifo_wr_en), 0);
      check("rst_wr_data", 32'(bus.fifo_wr_data), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_cur_src", 32'(cur_src), 0);
      check("rst_pkt_count", 32'(pkt_count), 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #2;

      // single source, three back-to-back bytes
      b0 = wcyc.size();
      send(2, 3, 8'h11, 8'h11, -1, 0);
      wait_done("single", 60);
      check("single_pkts", 32'(pkt_count), 1);
      check("single_cur", 32'(cur_src), 2);
      check("single_burst", 32'(wcyc[b0+TAGN+2] - wcyc[b0+TAGN]), 2);

      // pointer sits at 3: source 3 beats source 0
      send(3, 1, 8'h5A, 8'h00, -1, 0);
      send(0, 1, 8'hA5, 8'h00, -1, 0);
      wait_done("rr_wrap", 60);
      check("rr_wrap_pkts", 32'(pkt_count), 3);
      check("rr_wrap_cur", 32'(cur_src), 0);

      // contention from reset: 0,1,3 with 2-byte packets
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #2;
      b0 = wcyc.size();
      order = '{0, 1, 3};
      for (int k = 0; k < 3; k++)
         send(order[k], 2, 8'($urandom_range(0, 255)), 8'h01, -1, 0);
      wait_done("contend", 100);
      p = 2 + TAGN;
      for (int k = 0; k < 3; k++) begin
         check("contend_burst", 32'(wcyc[b0+k*p+p-1] - wcyc[b0+k*p]), 32'(p - 1));
         if (k > 0) check("contend_gap", 32'(wcyc[b0+k*p] - wcyc[b0+k*p-1]), 2);
      end
      check("contend_pkts", 32'(pkt_count), 3);
      check("contend_cur", 32'(cur_src), 3);

      // back-pressure on byte 2 of 4 for three cycles
      b0 = wcyc.size();
      send(1, 4, 8'($urandom_range(0, 255)), 8'h03, -1, 0);
      wait_writes("bp", b0 + TAGN + 1, 40);
      bus.fifo_full = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      bus.fifo_full = 1'b0;
      wait_done("bp", 60);
      check("bp_stall", 32'(wcyc[b0+TAGN+1] - wcyc[b0+TAGN]), 4);
      check("bp_pkts", 32'(pkt_count), 4);

      // valid gap of 2 cycles mid-packet while source 1 waits
      b0 = wcyc.size();
      send(0, 4, 8'($urandom_range(0, 255)), 8'h07, 2, 2);
      send(1, 1, 8'h3C, 8'h00, -1, 0);
      wait_done("vgap", 80);
      check("vgap_hold", 32'(wcyc[b0+TAGN+2] - wcyc[b0+TAGN+1]), 3);
      check("vgap_pkts", 32'(pkt_count), 6);
      check("vgap_cur", 32'(cur_src), 1);

      // reset after 2 of 5 bytes
      b0 = wcyc.size();
      send(2, 5, 8'($urandom_range(0, 255)), 8'h01, -1, 0);
      wait_writes("mid_rst", b0 + TAGN + 2, 40);
      rst = 1'b1;
      #1;
      check("mid_rst_ready", 32'(bus.src_ready), 0);
      check("mid_rst_wr_en", 32'(bus.fifo_wr_en), 0);
      check("mid_rst_wr_data", 32'(bus.fifo_wr_data), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_cur", 32'(cur_src), 0);
      check("mid_rst_pkts", 32'(pkt_count), 0);
      for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
      exp_q.delete();
      @(posedge clk);
      #2;
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #2;
      send(0, 2, 8'h40, 8'h01, -1, 0);
      send(3, 2, 8'h70, 8'h01, -1, 0);
      wait_done("post_rst", 80);
      check("post_rst_pkts", 32'(pkt_count), 2);
      check("post_rst_cur", 32'(cur_src), 3);

      // single-byte packet from source 3 (header 0x03 precedes it when tagging)
      send(3, 1, 8'hAB, 8'h00, -1, 0);
      wait_done("tag", 40);
      check("tag_pkts", 32'(pkt_count), 3);
      check("tag_exp_empty", 32'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Packet-granular round-robin arbiter sharing the write port of the byte FIFO between NUM_SRC traffic sources. Each source presents a byte stream with valid/ready/last; the arbiter locks onto one source for a whole packet, forwards its bytes to the FIFO write port at one byte per cycle, and stalls on FIFO full. It sits between the traffic capture front-ends and the FIFO, so packets from different sources never interleave in the buffer.

## Interface
- NUM_SRC, 4: number of requesting sources, 2..16.
- SEL_W, $clog2(NUM_SRC): width of source index (derived, not overridden).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- src_valid  in  NUM_SRC  per-source byte valid.
- src_data  in  NUM_SRC*8  per-source byte; source i at bits [8i+7:8i].
- src_last  in  NUM_SRC  per-source last byte of packet, qualified by src_valid.
- src_ready  out  NUM_SRC  per-source byte accepted this cycle when valid.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wr_data  out  8  FIFO write byte; 0 when fifo_wr_en low.
- busy  out  1  packet grant active (state not IDLE).
- cur_src  out  SEL_W  currently/last granted source index.
- pkt_count  out  16  completed packets, wraps at 65535 -> 0.

## Operation
- States: IDLE, TAG (only with SRC_TAG_EN), XFER.
- IDLE: if any src_valid, pick first requester at or after rr_ptr (wrapping modulo NUM_SRC); register grant into cur_src; next state TAG (tag enabled) or XFER. No bytes accepted in IDLE; src_ready all 0.
- TAG: fifo_wr_en = !fifo_full, fifo_wr_data = cur_src zero-extended; on write -> XFER; held while fifo_full.
- XFER: src_ready[cur_src] = !fifo_full, all other bits 0. fifo_wr_en = src_valid[cur_src] && !fifo_full; fifo_wr_data = that source's byte. On accepted beat with src_last: rr_ptr <= cur_src+1 (mod NUM_SRC), pkt_count++, -> IDLE.
- Grant held while granted source drops valid mid-packet; no timeout, no pre-emption.
- Requests from non-granted sources are ignored until IDLE; they wait (their src_ready 0).
- Single-byte packet (valid & last on first XFER beat) is legal: one write, back to IDLE.
- src_last without src_valid ignored.
- Reset mid-packet: immediately IDLE, rr_ptr 0; partial packet stays in FIFO (FIFO reset is the system's responsibility).
- Reset values: src_ready 0, fifo_wr_en 0, fifo_wr_data 0, busy 0, cur_src 0, pkt_count 0, rr_ptr 0.

## Timing
- src_ready, fifo_wr_en, fifo_wr_data combinational from state, cur_src, src_valid, fifo_full; zero-cycle pass-through of accepted bytes.
- fifo_full honored same cycle; its lag versus the FIFO count is the FIFO's property.
- Throughput 1 byte/cycle within packet; inter-packet overhead 1 cycle (IDLE), 2 cycles with tag.
- First byte of packet accepted earliest in cycle after the request is first seen in IDLE (2 cycles with tag).
- State, cur_src, rr_ptr, pkt_count update on clk rising edge.

## Configuration
- SRC_TAG_EN defined: TAG state present; every packet preceded in the FIFO by one header byte holding source index.
- Undefined: no TAG state, IDLE -> XFER directly, FIFO holds raw packet bytes only.

## Structure
- Package fifo_arb_pkg: state enum typedef (IDLE, TAG, XFER), byte width constant 8, pkt_count width constant 16.
- Sub-module rr_priority_picker: combinational, inputs request vector and rr_ptr, outputs found flag and winner index.

## Test plan
- Single source: src 2 sends bytes 0x11,0x22,0x33 (last on 0x33), fifo_full 0 -> three consecutive fifo_wr_en pulses with those bytes, pkt_count 1, rr_ptr 3.
- Contention: sources 0,1,3 all valid with 2-byte packets from reset -> packet order 0,1,3, no interleaving, 1 idle cycle between packets.
- Back-pressure: fifo_full raised during byte 2 of 4 for 3 cycles -> src_ready and fifo_wr_en low those cycles, no byte lost or duplicated.
- Valid gap: granted source deasserts valid 2 cycles mid-packet while source 1 requests -> grant kept, source 1 served only after last.
- Reset mid-packet: rst asserted after 2 of 5 bytes -> all outputs 0 asynchronously, next grant starts from source 0.
- SRC_TAG_EN: source 3 sends 0xAB (last) -> FIFO writes 0x03 then 0xAB.
